// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel-to-serial stage with one-word holding buffer
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   data_in     WIDTH-bit word, sampled when data_valid && data_ready
//   data_valid  upstream offers a word
//   data_ready  a word can be accepted this cycle (holding buffer empty)
//   bit_out     serial bit, 0 whenever no data bit is being presented
//   bit_valid   bit_out carries a data bit this cycle
//   busy        a word is being shifted or is buffered
//
// Build option:
//   BYTE_SERIALIZER_LSB_FIRST_EN  defined: emit LSB first (shift right);
//                                 undefined: emit MSB first (shift left).

module byte_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [WIDTH-1:0] hold_reg, hold_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             hold_full, hold_full_nxt;

  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic             head_bit;

`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
  assign shifted  = {1'b0, shift_reg[WIDTH-1:1]};
  assign head_bit = shift_reg[0];
`else
  assign shifted  = {shift_reg[WIDTH-2:0], 1'b0};
  assign head_bit = shift_reg[WIDTH-1];
`endif

  // Ready comes only from the buffer flag, so there is no valid->ready path.
  assign data_ready = !hold_full;
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      hold_reg  <= hold_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    hold_nxt      = hold_reg;
    bit_cnt_nxt   = bit_cnt;
    hold_full_nxt = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt   = data_in;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt != LAST_BIT) begin
          shift_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + CW'(1);
          if (accept) begin
            hold_nxt      = data_in;
            hold_full_nxt = 1'b1;
          end
        end else if (hold_full) begin
          // Buffered word goes next; ready was low so no accept competes.
          shift_nxt     = hold_reg;
          hold_full_nxt = 1'b0;
          bit_cnt_nxt   = '0;
        end else if (accept) begin
          // Word arriving on the last-bit edge skips the buffer entirely.
          shift_nxt   = data_in;
          bit_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bit_valid = (state == SHIFT);
  assign bit_out   = bit_valid && head_bit;
  assign busy      = bit_valid || hold_full;

endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - self-checking bench for byte_serializer

module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, bit_out, bit_valid, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fires = 0;
  logic [3:0] hist = '0;
  logic sbq[$];

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;
    int         nfire;
  } vec_t;
  vec_t vecs[6];

  byte_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Emission order of a word for the configured bit order.
  function automatic logic [7:0] ord(input logic [7:0] w);
    logic [7:0] r;
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  // Monitor: pops expected bits, models the 1011 detector on bit_out.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bit_valid) begin
          if (sbq.size() == 0) check("unexpected_bit", 32'(bit_out), 32'hx);
          else check("bit_out", 32'(bit_out), 32'(sbq.pop_front()));
        end else begin
          check("idle_bit_out", 32'(bit_out), 0);
        end
        hist = {hist[2:0], bit_out};
        if (hist == 4'b1011) fires++;
      end
    end
  end

  task automatic send_word(input logic [7:0] w, input logic [7:0] seq);
    logic acc = 1'b0;
    data_in    = w;
    data_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = data_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    else for (int i = 7; i >= 0; i--) sbq.push_back(seq[i]);
  endtask

  task automatic expect_valid_run(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(bit_valid), 1);
    end
  endtask

  task automatic expect_idle_after(input string name);
    @(negedge clk);
    check({name, "_valid_low"}, 32'(bit_valid), 0);
    check({name, "_bit_low"}, 32'(bit_out), 0);
    check({name, "_sb_empty"}, 32'(sbq.size()), 0);
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    vecs[0] = '{8'hB0, 8'b1011_0000, 1};
    vecs[1] = '{8'h80, 8'b1000_0000, 0};
    vecs[2] = '{8'h01, 8'b0000_0001, 0};
    vecs[3] = '{8'hA5, 8'b1010_0101, 0};
    vecs[4] = '{8'h2C, 8'b0010_1100, 1};
    vecs[5] = '{8'h0D, 8'b0000_1101, 0};
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
    vecs[0] = '{8'hB0, 8'b0000_1101, 0};
    vecs[1] = '{8'h80, 8'b0000_0001, 0};
    vecs[2] = '{8'h01, 8'b1000_0000, 0};
    vecs[3] = '{8'hA5, 8'b1010_0101, 0};
    vecs[4] = '{8'h2C, 8'b0011_0100, 0};
    vecs[5] = '{8'h0D, 8'b1011_0000, 1};
`endif

    // Reset state
    #2;
    check("rst_bit_valid", 32'(bit_valid), 0);
    check("rst_bit_out", 32'(bit_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(data_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single words from the table
    foreach (vecs[v]) begin
      f0 = fires;
      send_word(vecs[v].word, vecs[v].seq);
      data_valid = 1'b0;
      check("single_busy", 32'(busy), 1);
      expect_valid_run(8, "single_run");
      expect_idle_after("single");
      check("single_fires", 32'(fires - f0), 32'(vecs[v].nfire));
    end

    // Back-to-back with data_valid held high
    f0 = fires;
    send_word(8'hB6, ord(8'hB6));
    send_word(8'hD0, ord(8'hD0));
    data_valid = 1'b0;
    check("b2b_ready_low", 32'(data_ready), 0);
    check("b2b_busy", 32'(busy), 1);
    expect_valid_run(15, "b2b_run");
    expect_idle_after("b2b");
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
    check("b2b_fires", 32'(fires - f0), 2);
`else
    check("b2b_fires", 32'(fires - f0), 3);
`endif
    check("b2b_ready_back", 32'(data_ready), 1);

    // Last-bit bypass: 0x0F offered only on the previous word's last-bit edge
    send_word(8'hB0, ord(8'hB0));
    data_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("bypass_ready_pre", 32'(data_ready), 1);
    send_word(8'h0F, ord(8'h0F));
    data_valid = 1'b0;
    check("bypass_ready_post", 32'(data_ready), 1);
    expect_valid_run(8, "bypass_run");
    expect_idle_after("bypass");

    // Reset mid-word with a word buffered
    send_word(8'hFF, ord(8'hFF));
    send_word(8'hAA, ord(8'hAA));
    data_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    sbq.delete();
    #1;
    check("midrst_bit_valid", 32'(bit_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(data_ready), 1);
    check("midrst_bit_out", 32'(bit_out), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_idle_after("post_rst_quiet");
    send_word(8'h80, ord(8'h80));
    data_valid = 1'b0;
    expect_valid_run(8, "post_rst_run");
    expect_idle_after("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
